// File: rtl/sys_bus_arbiter_pkg.sv
// sys_bus_arbiter_pkg
//   Shared definitions for the system-bus arbiter: FSM state encoding and
//   the helper used to locate one master's field inside a flattened bus.
package sys_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_ACCESS = 2'd1,
    BUS_ACK    = 2'd2
  } bus_state_e;

  // Low bit of master idx's field in a flattened bus of width-w fields.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/sys_bus_arbiter_rr_picker.sv
// sys_bus_arbiter_rr_picker
//   Combinational round-robin winner selection.
//   Ports:
//     req    in  N       request vector
//     rr_ptr in  IW      master with highest priority this round
//     valid  out 1       at least one request present
//     winner out IW      index of the selected master
module sys_bus_arbiter_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] winner
);

  logic [N-1:0] rot;
  int           pos;

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then rotate
  // the found position back into master numbering.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[(i + int'(rr_ptr)) % N];
    end
    pos = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    valid  = |req;
    winner = IW'((pos + int'(rr_ptr)) % N);
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter
//   N-master round-robin arbiter in front of one synchronous memory port.
//   Each grant runs IDLE -> ACCESS (lat_cnt cycles) -> ACK (one cycle).
//   Ports:
//     sys_clk, reset        clock, synchronous active-high reset
//     req/addr/wr/wdata     per-master request, flattened address/data
//     ack                   one-hot single-cycle completion pulse
//     rd_data               registered read data, valid with ack
//     mem_addr/mem_we/mem_wdata/mem_rdata  memory port
//     busy                  high in any state but IDLE
//     grant_id              current or most recent grantee
module sys_bus_arbiter
  import sys_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_LATENCY = 1,
  localparam int GW    = $clog2(NUM_MASTERS),
  localparam int LAT_W = $clog2(MEM_LATENCY + 1)
) (
  input  logic                              sys_clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_MASTERS-1:0]            wr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_MASTERS-1:0]            ack,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic                              mem_we,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              busy,
  output logic [GW-1:0]                     grant_id
);

  bus_state_e             state_q, state_d;
  logic [LAT_W-1:0]       lat_cnt_q, lat_cnt_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                   mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;

  logic                   pick_valid;
  logic [GW-1:0]          pick_winner;

  sys_bus_arbiter_rr_picker #(
    .N  (NUM_MASTERS),
    .IW (GW)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    rd_data_d   = rd_data_q;
    ack_d       = '0;
    case (state_q)
      BUS_IDLE: begin
        if (pick_valid) begin
          grant_d     = pick_winner;
          mem_addr_d  = addr[slice_lo(int'(pick_winner), ADDR_WIDTH) +: ADDR_WIDTH];
          mem_wdata_d = wdata[slice_lo(int'(pick_winner), DATA_WIDTH) +: DATA_WIDTH];
          mem_we_d    = wr[pick_winner];
          lat_cnt_d   = wr[pick_winner] ? LAT_W'(1) : LAT_W'(MEM_LATENCY);
          state_d     = BUS_ACCESS;
        end
      end
      BUS_ACCESS: begin
        mem_we_d  = 1'b0;
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == LAT_W'(1)) begin
          // A write always finishes in its first ACCESS cycle, where mem_we_q
          // is still high; a read never has mem_we_q set, so it marks reads.
          if (!mem_we_q) rd_data_d = mem_rdata;
          ack_d[grant_q] = 1'b1;
          rr_ptr_d = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = BUS_ACK;
        end
      end
      BUS_ACK: begin
        state_d = BUS_IDLE;
      end
      default: begin
        state_d = BUS_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= BUS_IDLE;
      lat_cnt_q   <= '0;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      rd_data_q   <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rd_data_q   <= rd_data_d;
      ack_q       <= ack_d;
    end
  end

  assign ack       = ack_q;
  assign rd_data   = rd_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != BUS_IDLE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter
//   Directed bench: instance A (2 masters, latency 1) and instance B
//   (4 masters, latency 3), each with its own memory model.
module tb_sys_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_MASTERS=2, MEM_LATENCY=1
  logic        a_rst;
  logic [1:0]  a_req, a_wr, a_ack;
  logic [31:0] a_addr;
  logic [15:0] a_wdata;
  logic [7:0]  a_rd, a_mrd, a_mwd;
  logic [15:0] a_maddr;
  logic        a_mwe, a_busy;
  logic [0:0]  a_gid;

  // Instance B: NUM_MASTERS=4, MEM_LATENCY=3
  logic        b_rst;
  logic [3:0]  b_req, b_wr, b_ack;
  logic [63:0] b_addr;
  logic [31:0] b_wdata;
  logic [7:0]  b_rd, b_mrd, b_mwd;
  logic [15:0] b_maddr;
  logic        b_mwe, b_busy;
  logic [1:0]  b_gid;

  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:1023];

  assign a_mrd = mem_a[a_maddr[9:0]];
  assign b_mrd = mem_b[b_maddr[9:0]];

  always @(posedge clk) begin
    if (a_mwe) mem_a[a_maddr[9:0]] <= a_mwd;
    if (b_mwe) mem_b[b_maddr[9:0]] <= b_mwd;
  end

  sys_bus_arbiter #(
    .NUM_MASTERS (2),
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (8),
    .MEM_LATENCY (1)
  ) u_a (
    .sys_clk   (clk),
    .reset     (a_rst),
    .req       (a_req),
    .addr      (a_addr),
    .wr        (a_wr),
    .wdata     (a_wdata),
    .ack       (a_ack),
    .rd_data   (a_rd),
    .mem_addr  (a_maddr),
    .mem_we    (a_mwe),
    .mem_wdata (a_mwd),
    .mem_rdata (a_mrd),
    .busy      (a_busy),
    .grant_id  (a_gid)
  );

  sys_bus_arbiter #(
    .NUM_MASTERS (4),
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (8),
    .MEM_LATENCY (3)
  ) u_b (
    .sys_clk   (clk),
    .reset     (b_rst),
    .req       (b_req),
    .addr      (b_addr),
    .wr        (b_wr),
    .wdata     (b_wdata),
    .ack       (b_ack),
    .rd_data   (b_rd),
    .mem_addr  (b_maddr),
    .mem_we    (b_mwe),
    .mem_wdata (b_mwd),
    .mem_rdata (b_mrd),
    .busy      (b_busy),
    .grant_id  (b_gid)
  );

  int tests = 0;
  int fails = 0;

  int         rr_exp [5] = '{0, 2, 3, 0, 2};
  logic [7:0] rr_dat [5] = '{8'h5A, 8'hC3, 8'h77, 8'h5A, 8'hC3};

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; signals are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] ack_seq;
    logic [5:0] ack_bb, busy_bb;

    a_rst = 1'b1; a_req = '0; a_wr = '0; a_addr = '0; a_wdata = '0;
    b_rst = 1'b1; b_req = '0; b_wr = '0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[10'h010] = 8'hA5;
    mem_b[10'h123] = 8'h5A;
    mem_b[10'h200] = 8'hC3;
    mem_b[10'h300] = 8'h77;
    b_addr[0*16 +: 16] = 16'h0123;
    b_addr[1*16 +: 16] = 16'h0100;
    b_addr[2*16 +: 16] = 16'h0200;
    b_addr[3*16 +: 16] = 16'h0300;

    tick(); tick();
    check_eq("rst_a_ack",   a_ack,   0);
    check_eq("rst_a_busy",  a_busy,  0);
    check_eq("rst_a_maddr", a_maddr, 0);
    check_eq("rst_a_mwe",   a_mwe,   0);
    check_eq("rst_a_rd",    a_rd,    0);
    check_eq("rst_a_gid",   a_gid,   0);
    check_eq("rst_b_ack",   b_ack,   0);
    check_eq("rst_b_busy",  b_busy,  0);
    check_eq("rst_b_mwd",   b_mwd,   0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Single read on A: master 0 reads 0x0010 -> 0xA5.
    a_addr[15:0] = 16'h0010; a_wr = 2'b00; a_req = 2'b01;
    tick();
    check_eq("rd1_maddr", a_maddr, 16'h0010);
    check_eq("rd1_ack_t1", a_ack, 2'b00);
    check_eq("rd1_busy_t1", a_busy, 1);
    check_eq("rd1_mwe_t1", a_mwe, 0);
    tick();
    check_eq("rd1_ack_t2", a_ack, 2'b01);
    check_eq("rd1_data", a_rd, 8'hA5);
    check_eq("rd1_gid", a_gid, 0);
    a_req = 2'b00;
    tick();
    check_eq("rd1_ack_t3", a_ack, 2'b00);
    check_eq("rd1_busy_t3", a_busy, 0);
    check_eq("rd1_hold", a_rd, 8'hA5);

    // Write on A: master 1 writes 0x3C to 0x0040, then reads it back.
    a_addr[31:16] = 16'h0040; a_wdata[15:8] = 8'h3C; a_wr = 2'b10; a_req = 2'b10;
    tick();
    check_eq("wr_mwe_t1", a_mwe, 1);
    check_eq("wr_mwd_t1", a_mwd, 8'h3C);
    check_eq("wr_maddr", a_maddr, 16'h0040);
    check_eq("wr_gid", a_gid, 1);
    check_eq("wr_ack_t1", a_ack, 2'b00);
    tick();
    check_eq("wr_ack_t2", a_ack, 2'b10);
    check_eq("wr_mwe_t2", a_mwe, 0);
    check_eq("wr_rd_kept", a_rd, 8'hA5);
    a_req = 2'b00;
    tick();
    check_eq("wr_ack_t3", a_ack, 2'b00);
    a_wr = 2'b00; a_req = 2'b10;
    tick();
    check_eq("rb_mwe", a_mwe, 0);
    tick();
    check_eq("rb_ack", a_ack, 2'b10);
    check_eq("rb_data", a_rd, 8'h3C);
    a_req = 2'b00;
    tick();

    // Back-to-back on A: master 0 holds req through ack.
    ack_bb  = 6'b010010;
    busy_bb = 6'b011011;
    a_req = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("bb_ack", a_ack, ack_bb[i] ? 2'b01 : 2'b00);
      check_eq("bb_busy", a_busy, busy_bb[i]);
      if (i == 4) a_req = 2'b00;
    end

    // Round-robin on B: masters 0, 2, 3 hold req from reset.
    b_req = 4'b1101;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (b_ack == 4'b0000 && n < 12);
      check_eq("rr_gap", n, (g == 0) ? 4 : 5);
      check_eq("rr_ack", b_ack, 4'b0001 << rr_exp[g]);
      check_eq("rr_gid", b_gid, rr_exp[g]);
      check_eq("rr_data", b_rd, rr_dat[g]);
      if (g == 4) b_req = 4'b0000;
    end
    tick();

    // Latency sweep on B: read 0x0123 -> 0x5A, ack at T+4, busy T+1..T+4.
    b_req = 4'b0001;
    ack_seq = '0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq("lat_ack", b_ack, (i == 4) ? 4'b0001 : 4'b0000);
      check_eq("lat_busy", b_busy, (i <= 4) ? 1 : 0);
      if (i == 1) check_eq("lat_maddr", b_maddr, 16'h0123);
      if (i == 4) begin
        check_eq("lat_data", b_rd, 8'h5A);
        b_req = 4'b0000;
      end
    end

    // Reset mid-read on B: rr_ptr is 1, so master 2 wins first.
    b_req = 4'b0101;
    tick();
    check_eq("mr_gid_pre", b_gid, 2);
    check_eq("mr_busy_pre", b_busy, 1);
    b_rst = 1'b1;
    tick();
    check_eq("mr_ack", b_ack, 0);
    check_eq("mr_busy", b_busy, 0);
    check_eq("mr_maddr", b_maddr, 0);
    check_eq("mr_mwe", b_mwe, 0);
    check_eq("mr_mwd", b_mwd, 0);
    check_eq("mr_rd", b_rd, 0);
    check_eq("mr_gid", b_gid, 0);
    b_rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (b_ack == 4'b0000 && n < 12);
    check_eq("mr_gap0", n, 4);
    check_eq("mr_ack0", b_ack, 4'b0001);
    check_eq("mr_data0", b_rd, 8'h5A);
    b_req = 4'b0100;
    n = 0;
    do begin
      tick();
      n++;
    end while (b_ack == 4'b0000 && n < 12);
    check_eq("mr_gap2", n, 5);
    check_eq("mr_ack2", b_ack, 4'b0100);
    check_eq("mr_data2", b_rd, 8'hC3);
    b_req = 4'b0000;
    tick();
    check_eq("mr_ack_end", b_ack, 0);
    tick();
    check_eq("mr_busy_end", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
